// File: rtl/out_uart_bridge_pkg.sv
// Shared state encoding and frame constants for the CPU output-port UART bridge.
// Defining OUT_UART_PARITY_EN switches every byte frame from 8N1 to 8E1.
package out_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic BYTE_HIGH = 1'b0;
    localparam logic BYTE_LOW  = 1'b1;

`ifdef OUT_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/out_uart_bridge_if.sv
// Bundle between the CPU output register and the UART bridge.
// The master side is the CPU/board; the bridge attaches to the slave modport.
interface out_uart_bridge_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready,
        input  tx,
        input  busy,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready,
        output tx,
        output busy,
        output fifo_count,
        output overflow
    );

endinterface

// File: rtl/out_uart_bridge_uart_tx_core.sv
// Byte serializer: one start bit, 8 data bits LSB first, optional even parity
// (OUT_UART_PARITY_EN), one stop bit. A byte offered on the last STOP cycle
// chains straight into the next START with no idle gap.
//
//   state  | meaning
//   IDLE   | line high, waiting for i_byte_valid
//   START  | tx=0 for one bit time
//   DATA   | 8 data bits, r_bit counts 0..7
//   PARITY | even parity of the byte (parity builds only)
//   STOP   | tx=1 for one bit time; o_byte_done on its last cycle
module uart_tx_core
    import out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_done,
    output logic       o_idle,
    output logic       o_tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef OUT_UART_PARITY_EN
    logic          r_parity;
`endif
    logic          w_bit_end;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign o_byte_done = (r_state == STOP) && w_bit_end;
    assign o_idle      = (r_state == IDLE);
    assign o_tx        = r_tx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef OUT_UART_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE) begin
                r_baud <= '0;
            end else begin
                r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (i_byte_valid) begin
                        r_state  <= START;
                        r_baud   <= '0;
                        r_shift  <= i_byte_data;
                        r_tx     <= 1'b0;
`ifdef OUT_UART_PARITY_EN
                        r_parity <= ^i_byte_data;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (i_byte_valid) begin
                            r_state  <= START;
                            r_baud   <= '0;
                            r_shift  <= i_byte_data;
                            r_tx     <= 1'b0;
`ifdef OUT_UART_PARITY_EN
                            r_parity <= ^i_byte_data;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/out_uart_bridge.sv
// Buffers 16-bit CPU output words in a FIFO and sends each as two UART bytes,
// high byte first. OUT_UART_PARITY_EN adds an even-parity bit to every byte.
module out_uart_bridge
    import out_uart_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clock,
    input  logic            reset,
    out_uart_bridge_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_byte_sel;
    logic [7:0]    r_low_byte;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_core_idle;
    logic          w_byte_done;
    logic          w_next_low;
    logic          w_byte_valid;
    logic [7:0]    w_byte_data;
    logic [15:0]   w_head;
    logic          w_tx;

    // Full uses the pre-edge count, so a push against a full FIFO is dropped
    // even if a pop happens on the same edge.
    assign w_full       = (r_count == FULL_COUNT);
    assign w_push       = bus.out_valid && !w_full;
    assign w_pop        = w_core_idle && (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_next_low   = w_byte_done && (r_byte_sel == BYTE_HIGH);
    assign w_byte_valid = w_pop || w_next_low;
    assign w_byte_data  = w_pop ? w_head[15:8] : r_low_byte;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.out_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_byte_sel <= BYTE_HIGH;
            r_low_byte <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_low_byte <= w_head[7:0];
                r_byte_sel <= BYTE_HIGH;
            end else if (w_next_low) begin
                r_byte_sel <= BYTE_LOW;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.out_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_core (
        .clock       (clock),
        .reset       (reset),
        .i_byte_valid(w_byte_valid),
        .i_byte_data (w_byte_data),
        .o_byte_done (w_byte_done),
        .o_idle      (w_core_idle),
        .o_tx        (w_tx)
    );

    assign bus.out_ready  = !w_full;
    assign bus.tx         = w_tx;
    assign bus.busy       = !w_core_idle || (r_count != '0);
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;

endmodule
